// File: rtl/clock_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_divider_pkg
//  Description : Shared constants for the configurable clock divider:
//                controller state encoding, minimum half-period and the
//                default half-period counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_divider_pkg;

    // Default width of the half-period counter
    localparam int DIV_HALF_WIDTH_DEFAULT = 16;

    // Smallest legal half-period; a request of 0 is raised to this
    localparam int DIV_HALF_MIN = 1;

    // Controller state encoding
    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

endpackage : clock_divider_pkg
`default_nettype wire

// File: rtl/clock_divider_core.sv
`default_nettype none
// ============================================================================
//  Module      : clock_divider_core
//  Description : Half-period counter and output toggle of the configurable
//                divider. Produces the registered divided clock, a one-cycle
//                tick on each rising edge of it, and a combinational flag
//                marking the cycle whose edge ends a full period (1->0).
//                A synchronous load replaces the half-period and restarts
//                the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_core
    import clock_divider_pkg::*;
#(
    parameter int FREQUENCY_DIV_HALF_BIT_WIDTH = DIV_HALF_WIDTH_DEFAULT,
    parameter int FREQUENCY_DIV_HALF_DEFAULT   = 25000
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    run,
    input  logic                                    load,
    input  logic [FREQUENCY_DIV_HALF_BIT_WIDTH-1:0] load_div_half,
    output logic                                    clk_div,
    output logic                                    tick,
    output logic                                    boundary,
    output logic [FREQUENCY_DIV_HALF_BIT_WIDTH-1:0] div_half_active
);

    localparam logic [FREQUENCY_DIV_HALF_BIT_WIDTH-1:0] c_one =
        FREQUENCY_DIV_HALF_BIT_WIDTH'(1);
    localparam logic [FREQUENCY_DIV_HALF_BIT_WIDTH-1:0] c_div_default =
        FREQUENCY_DIV_HALF_BIT_WIDTH'(FREQUENCY_DIV_HALF_DEFAULT);

    logic [FREQUENCY_DIV_HALF_BIT_WIDTH-1:0] r_cnt;
    logic [FREQUENCY_DIV_HALF_BIT_WIDTH-1:0] r_div_half;
    logic                                    r_clk_div;
    logic                                    r_tick;
    logic                                    w_wrap;

    // Last count of the current half-period (half-period is never 0)
    assign w_wrap = (r_cnt == (r_div_half - c_one));

    // Count half-periods, toggle the output, pulse tick on the rising toggle;
    // a load restarts the count with the new half-period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_clk_div  <= 1'b0;
            r_tick     <= 1'b0;
            r_div_half <= c_div_default;
        end else begin
            r_tick <= 1'b0;
            if (run) begin
                if (w_wrap) begin
                    r_cnt     <= '0;
                    r_clk_div <= ~r_clk_div;
                    r_tick    <= ~r_clk_div;
                end else begin
                    r_cnt <= r_cnt + c_one;
                end
            end else begin
                r_cnt     <= '0;
                r_clk_div <= 1'b0;
            end
            if (load) begin
                r_cnt      <= '0;
                r_div_half <= load_div_half;
            end
        end
    end

    assign boundary        = run & w_wrap & r_clk_div;
    assign clk_div         = r_clk_div;
    assign tick            = r_tick;
    assign div_half_active = r_div_half;

endmodule : clock_divider_core
`default_nettype wire

// File: rtl/clock_divider_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_divider_cfg
//  Description : Run-time programmable clock divider. A valid/ready port
//                accepts a new half-period and run/stop request; while the
//                divider runs, the request is held pending and applied only
//                on a full-period boundary so the output never glitches.
//                Optional macro CLOCK_DIVIDER_CFG_PERIOD_COUNT_EN adds a
//                saturating period counter output (period_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_cfg
    import clock_divider_pkg::*;
#(
    parameter int FREQUENCY_DIV_HALF_BIT_WIDTH = DIV_HALF_WIDTH_DEFAULT,
    parameter int FREQUENCY_DIV_HALF_DEFAULT   = 25000
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [FREQUENCY_DIV_HALF_BIT_WIDTH-1:0] cfg_div_half,
    input  logic                                    cfg_enable,
    output logic                                    clk_div,
    output logic                                    tick,
    output logic                                    busy,
    output logic [FREQUENCY_DIV_HALF_BIT_WIDTH-1:0] div_half_active
`ifdef CLOCK_DIVIDER_CFG_PERIOD_COUNT_EN
    ,
    output logic [15:0]                             period_cnt
`endif
);

    logic [1:0]                              r_state;
    logic                                    r_cfg_ready;
    logic                                    r_busy;
    logic [FREQUENCY_DIV_HALF_BIT_WIDTH-1:0] r_pend_div;
    logic                                    r_pend_en;

    logic                                    w_accept;
    logic                                    w_run;
    logic                                    w_load;
    logic                                    w_boundary;
    logic [FREQUENCY_DIV_HALF_BIT_WIDTH-1:0] w_cfg_div_clamped;
    logic [FREQUENCY_DIV_HALF_BIT_WIDTH-1:0] w_load_div;

    assign w_accept          = cfg_valid & r_cfg_ready;
    assign w_cfg_div_clamped = (cfg_div_half == '0)
                             ? FREQUENCY_DIV_HALF_BIT_WIDTH'(DIV_HALF_MIN)
                             : cfg_div_half;
    assign w_run             = (r_state != ST_STOPPED);

    // Stopped: apply immediately. Pending: apply on the period boundary.
    assign w_load     = ((r_state == ST_STOPPED) && w_accept)
                     || ((r_state == ST_PENDING) && w_boundary);
    assign w_load_div = (r_state == ST_STOPPED) ? w_cfg_div_clamped : r_pend_div;

    // Controller: handshake, pending request capture and apply sequencing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RUNNING;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_pend_div  <= '0;
            r_pend_en   <= 1'b0;
        end else begin
            case (r_state)
                ST_STOPPED: begin
                    if (w_accept && cfg_enable) begin
                        r_state <= ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (w_accept) begin
                        r_pend_div  <= w_cfg_div_clamped;
                        r_pend_en   <= cfg_enable;
                        r_state     <= ST_PENDING;
                        r_cfg_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (w_boundary) begin
                        r_state     <= r_pend_en ? ST_RUNNING : ST_STOPPED;
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_STOPPED;
                    r_cfg_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    clock_divider_core #(
        .FREQUENCY_DIV_HALF_BIT_WIDTH (FREQUENCY_DIV_HALF_BIT_WIDTH),
        .FREQUENCY_DIV_HALF_DEFAULT   (FREQUENCY_DIV_HALF_DEFAULT)
    ) u_core (
        .clk             (clk),
        .reset_n         (reset_n),
        .run             (w_run),
        .load            (w_load),
        .load_div_half   (w_load_div),
        .clk_div         (clk_div),
        .tick            (tick),
        .boundary        (w_boundary),
        .div_half_active (div_half_active)
    );

    assign cfg_ready = r_cfg_ready;
    assign busy      = r_busy;

`ifdef CLOCK_DIVIDER_CFG_PERIOD_COUNT_EN
    logic [15:0] r_period_cnt;

    // Count rising edges of the divided clock since the last applied config
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period_cnt <= 16'h0000;
        end else if (w_load) begin
            r_period_cnt <= 16'h0000;
        end else if (tick && (r_period_cnt != 16'hFFFF)) begin
            r_period_cnt <= r_period_cnt + 16'h0001;
        end
    end

    assign period_cnt = r_period_cnt;
`endif

endmodule : clock_divider_cfg
`default_nettype wire

// File: tb/tb_clock_divider_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_divider_cfg
//  Description : Self-checking bench for clock_divider_cfg with a default
//                half-period of 4. Expected per-cycle outputs
//                {clk_div, tick, busy, cfg_ready, div_half_active} are queued
//                when stimulus is planned and popped one per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_divider_cfg;

    localparam int W   = 16;
    localparam int DEF = 4;

    logic         clk          = 1'b0;
    logic         reset_n      = 1'b1;
    logic         cfg_valid    = 1'b0;
    logic         cfg_enable   = 1'b0;
    logic [W-1:0] cfg_div_half = '0;
    logic         cfg_ready;
    logic         clk_div;
    logic         tick;
    logic         busy;
    logic [W-1:0] div_half_active;
`ifdef CLOCK_DIVIDER_CFG_PERIOD_COUNT_EN
    logic [15:0]  period_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    logic [19:0] sbq[$];
    wire  [19:0] obs = {clk_div, tick, busy, cfg_ready, div_half_active};

    clock_divider_cfg #(
        .FREQUENCY_DIV_HALF_BIT_WIDTH (W),
        .FREQUENCY_DIV_HALF_DEFAULT   (DEF)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_div_half    (cfg_div_half),
        .cfg_enable      (cfg_enable),
        .clk_div         (clk_div),
        .tick            (tick),
        .busy            (busy),
        .div_half_active (div_half_active)
`ifdef CLOCK_DIVIDER_CFG_PERIOD_COUNT_EN
        ,
        .period_cnt      (period_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ev(input logic c, input logic t, input logic b,
                                       input logic r, input logic [15:0] d);
        return {c, t, b, r, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue n cycles of one clk_div level; first_tick marks a rising edge
    task automatic push_phase(input logic lvl, input int n, input logic bsy, input logic rdy,
                              input logic [15:0] d, input logic first_tick);
        for (int i = 0; i < n; i++) begin
            sbq.push_back(ev(lvl, first_tick && (i == 0), bsy, rdy, d));
        end
    endtask

    // Advance to the next cycle showing tick, bounded
    task automatic sync_rise(input string name);
        int k;
        k = 0;
        while (tick !== 1'b1 && k < 64) begin
            step();
            k++;
        end
        n_vec++;
        if (tick !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_sync: tick=%b after %0d cycles, want 1", name, tick, k);
        end
    endtask

    task automatic test_reset();
        logic [19:0] e;
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== ev(0, 0, 0, 1, 16'(DEF))) begin
            n_bad++;
            $display("FAIL reset_async: got ctl=%b div=%0d want ctl=0001 div=%0d",
                     obs[19:16], obs[15:0], DEF);
        end
        repeat (3) step();
        n_vec++;
        if (obs !== ev(0, 0, 0, 1, 16'(DEF))) begin
            n_bad++;
            $display("FAIL reset_held: got ctl=%b div=%0d want ctl=0001 div=%0d",
                     obs[19:16], obs[15:0], DEF);
        end
        reset_n = 1'b1;
        push_phase(0, 4, 0, 1, 16'(DEF), 0);
        push_phase(1, 4, 0, 1, 16'(DEF), 1);
        push_phase(0, 4, 0, 1, 16'(DEF), 0);
        push_phase(1, 1, 0, 1, 16'(DEF), 1);
        for (int i = 0; sbq.size() > 0; i++) begin
            e = sbq.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_freerun[%0d]: got ctl=%b div=%0d want ctl=%b div=%0d",
                         i, obs[19:16], obs[15:0], e[19:16], e[15:0]);
            end
            step();
        end
    endtask

    task automatic test_reload();
        logic [19:0] e;
        sync_rise("reload");
        sbq.push_back(ev(1, 1, 0, 1, 16'd4));
        push_phase(1, 3, 1, 0, 16'd4, 0);
        push_phase(0, 2, 0, 1, 16'd2, 0);
        push_phase(1, 2, 0, 1, 16'd2, 1);
        push_phase(0, 2, 0, 1, 16'd2, 0);
        push_phase(1, 2, 0, 1, 16'd2, 1);
        for (int i = 0; sbq.size() > 0; i++) begin
            e = sbq.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reload[%0d]: got ctl=%b div=%0d want ctl=%b div=%0d",
                         i, obs[19:16], obs[15:0], e[19:16], e[15:0]);
            end
            if (i == 0) begin
                cfg_valid = 1'b1; cfg_div_half = 16'd2; cfg_enable = 1'b1;
            end else if (i == 1) begin
                cfg_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_stop();
        logic [19:0] e;
        sync_rise("stop");
        sbq.push_back(ev(1, 1, 0, 1, 16'd2));
        sbq.push_back(ev(1, 0, 1, 0, 16'd2));
        push_phase(0, 11, 0, 1, 16'd5, 0);
        for (int i = 0; sbq.size() > 0; i++) begin
            e = sbq.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL stop[%0d]: got ctl=%b div=%0d want ctl=%b div=%0d",
                         i, obs[19:16], obs[15:0], e[19:16], e[15:0]);
            end
            if (i == 0) begin
                cfg_valid = 1'b1; cfg_div_half = 16'd5; cfg_enable = 1'b0;
            end else if (i == 1) begin
                cfg_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_restart();
        logic [19:0] e;
        sbq.push_back(ev(0, 0, 0, 1, 16'd5));
        push_phase(0, 3, 0, 1, 16'd3, 0);
        push_phase(1, 3, 0, 1, 16'd3, 1);
        push_phase(0, 3, 0, 1, 16'd3, 0);
        push_phase(1, 1, 0, 1, 16'd3, 1);
        for (int i = 0; sbq.size() > 0; i++) begin
            e = sbq.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL restart[%0d]: got ctl=%b div=%0d want ctl=%b div=%0d",
                         i, obs[19:16], obs[15:0], e[19:16], e[15:0]);
            end
            if (i == 0) begin
                cfg_valid = 1'b1; cfg_div_half = 16'd3; cfg_enable = 1'b1;
            end else if (i == 1) begin
                cfg_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_zero_clamp();
        logic [19:0] e;
        sync_rise("zero_clamp");
        sbq.push_back(ev(1, 1, 0, 1, 16'd3));
        push_phase(1, 2, 1, 0, 16'd3, 0);
        for (int k = 0; k < 4; k++) begin
            push_phase(0, 1, 0, 1, 16'd1, 0);
            push_phase(1, 1, 0, 1, 16'd1, 1);
        end
        push_phase(0, 1, 0, 1, 16'd1, 0);
        for (int i = 0; sbq.size() > 0; i++) begin
            e = sbq.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL zero_clamp[%0d]: got ctl=%b div=%0d want ctl=%b div=%0d",
                         i, obs[19:16], obs[15:0], e[19:16], e[15:0]);
            end
            if (i == 0) begin
                cfg_valid = 1'b1; cfg_div_half = 16'd0; cfg_enable = 1'b1;
            end else if (i == 1) begin
                cfg_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] e;
        sync_rise("back_to_back");
        sbq.push_back(ev(1, 1, 0, 1, 16'd1));
        sbq.push_back(ev(0, 0, 1, 0, 16'd1));
        sbq.push_back(ev(1, 1, 1, 0, 16'd1));
        sbq.push_back(ev(0, 0, 0, 1, 16'd2));
        sbq.push_back(ev(0, 0, 1, 0, 16'd2));
        sbq.push_back(ev(1, 1, 1, 0, 16'd2));
        sbq.push_back(ev(1, 0, 1, 0, 16'd2));
        push_phase(0, 3, 0, 1, 16'd3, 0);
        push_phase(1, 1, 0, 1, 16'd3, 1);
        for (int i = 0; sbq.size() > 0; i++) begin
            e = sbq.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got ctl=%b div=%0d want ctl=%b div=%0d",
                         i, obs[19:16], obs[15:0], e[19:16], e[15:0]);
            end
            if (i == 0) begin
                cfg_valid = 1'b1; cfg_div_half = 16'd2; cfg_enable = 1'b1;
            end else if (i == 1) begin
                cfg_div_half = 16'd3;
            end else if (i == 4) begin
                cfg_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset_pending();
        logic [19:0] e;
        sync_rise("reset_pending");
        sbq.push_back(ev(1, 1, 0, 1, 16'd3));
        sbq.push_back(ev(1, 0, 1, 0, 16'd3));
        for (int i = 0; sbq.size() > 0; i++) begin
            e = sbq.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_pending_pre[%0d]: got ctl=%b div=%0d want ctl=%b div=%0d",
                         i, obs[19:16], obs[15:0], e[19:16], e[15:0]);
            end
            if (i == 0) begin
                cfg_valid = 1'b1; cfg_div_half = 16'd6; cfg_enable = 1'b0;
            end else if (i == 1) begin
                cfg_valid = 1'b0;
            end
            step();
        end
        #3 reset_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== ev(0, 0, 0, 1, 16'(DEF))) begin
            n_bad++;
            $display("FAIL reset_pending_async: got ctl=%b div=%0d want ctl=0001 div=%0d",
                     obs[19:16], obs[15:0], DEF);
        end
        step();
        step();
        reset_n = 1'b1;
        push_phase(0, 4, 0, 1, 16'(DEF), 0);
        push_phase(1, 4, 0, 1, 16'(DEF), 1);
        push_phase(0, 4, 0, 1, 16'(DEF), 0);
        push_phase(1, 1, 0, 1, 16'(DEF), 1);
        for (int i = 0; sbq.size() > 0; i++) begin
            e = sbq.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_pending_post[%0d]: got ctl=%b div=%0d want ctl=%b div=%0d",
                         i, obs[19:16], obs[15:0], e[19:16], e[15:0]);
            end
            step();
        end
    endtask

`ifdef CLOCK_DIVIDER_CFG_PERIOD_COUNT_EN
    task automatic test_period_count();
        int k;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int p = 0; p < 5; p++) begin
            sync_rise("period_count");
            step();
        end
        n_vec++;
        if (period_cnt !== 16'd5) begin
            n_bad++;
            $display("FAIL period_count_5: got %0d want 5", period_cnt);
        end
        cfg_valid = 1'b1; cfg_div_half = 16'd2; cfg_enable = 1'b1;
        step();
        cfg_valid = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 32) begin
            step();
            k++;
        end
        n_vec++;
        if (period_cnt !== 16'd0 || div_half_active !== 16'd2) begin
            n_bad++;
            $display("FAIL period_count_clear: got cnt=%0d div=%0d want cnt=0 div=2",
                     period_cnt, div_half_active);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reload();
        test_stop();
        test_restart();
        test_zero_clamp();
        test_back_to_back();
        test_reset_pending();
`ifdef CLOCK_DIVIDER_CFG_PERIOD_COUNT_EN
        test_period_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_clock_divider_cfg
`default_nettype wire

// File: doc/clock_divider_cfg.md
Name: clock_divider_cfg

Overview:
- Run-time programmable clock divider with a controller that reconfigures the divide ratio and run/stop state through a valid/ready handshake.
- Changes take effect only at full-period boundaries, so the divided clock never glitches.
- Sits beside the fixed dividers in the clock subsystem. Serves consumers whose rate changes at run time, such as the audio tone or volume paths.
- Out of reset it free-runs at a default ratio, like the fixed dividers.

Parameters:
- FREQUENCY_DIV_HALF_BIT_WIDTH, 16: width of the half-period count.
- FREQUENCY_DIV_HALF_DEFAULT, 25000: half-period, in clk cycles, loaded at reset.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- cfg_valid  input  1  configuration request.
- cfg_ready  output  1  the block can accept a configuration this cycle.
- cfg_div_half  input  FREQUENCY_DIV_HALF_BIT_WIDTH  requested half-period in clk cycles.
- cfg_enable  input  1  requested run (1) or stop (0).
- clk_div  output  1  divided clock, registered.
- tick  output  1  one-clk pulse in the cycle clk_div rises.
- busy  output  1  a configuration is pending and not yet applied.
- div_half_active  output  FREQUENCY_DIV_HALF_BIT_WIDTH  half-period currently in use.

Behaviour:
- Reset values:
  - clk_div=0, tick=0, busy=0, cfg_ready=1.
  - div_half_active=FREQUENCY_DIV_HALF_DEFAULT, cnt=0, state=RUNNING.
- An asserted reset_n=0 aborts everything immediately, including a pending configuration.
- Clamping: cfg_div_half=0 is stored as 1. The minimum half-period is 1, giving clk_div=clk/2.
- Counting (RUNNING or PENDING):
  - When cnt==div_half_active-1: cnt<=0 and clk_div toggles. Otherwise cnt<=cnt+1.
  - tick=1 in the same cycle clk_div goes 0->1, and 0 otherwise.
- Period boundary: the cycle in which clk_div toggles 1->0.
- States:
  - STOPPED: clk_div held 0, cnt held 0, cfg_ready=1. On accept (cfg_valid&cfg_ready), apply next cycle: div_half_active<=clamped value, cnt<=0. Go to RUNNING if cfg_enable=1, else stay in STOPPED. busy never asserts here.
  - RUNNING: cfg_ready=1. On accept, latch the pending half-period and pending enable, then go to PENDING. busy=1 from the next cycle.
  - PENDING: cfg_ready=0. At the next period boundary, apply the pending half-period (cnt<=0) and the pending enable (1 -> RUNNING, 0 -> STOPPED), then clear busy.
- Apply latency: first period with the new ratio starts on the cycle after the boundary. Latency is at most one full old period plus 1 cycle.
- Accept in the same cycle as a boundary: that boundary still uses the old value; the new value applies at the following boundary.
- Identical reconfiguration is still handled as a full handshake; there is no shortcut.
- When stopping, clk_div ends low with a complete final high phase. There are no runt pulses.

Optional Feature:
- Macro: CLOCK_DIVIDER_CFG_PERIOD_COUNT_EN.
- When defined:
  - Adds output period_cnt, 16 bits, wide enough for the test-plan values.
  - It increments on every tick and saturates at 16'hFFFF.
  - It clears to 0 on reset and on every applied configuration.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package clock_divider_pkg holds:
  - state encoding constants ST_STOPPED, ST_RUNNING, ST_PENDING;
  - DIV_HALF_MIN=1;
  - the default bit width.
- One sub-module, clock_divider_core: counter, toggle, tick, plus a synchronous load/clear port.
- The controller FSM, the pending register and the handshake stay in clock_divider_cfg.

Test Plan:
- Reset -> default free-run: release reset with DEFAULT=4 -> clk_div low 4 cycles, high 4, repeating; tick once per 8 cycles; cfg_ready=1.
- Glitch-free reload: while RUNNING, send cfg_div_half=2, enable=1 -> busy=1 until the next 1->0 boundary; then exactly 2-high/2-low periods; no phase shorter than 2 or 4.
- Stop and restart:
  - Send enable=0 mid-high-phase -> the high phase completes, clk_div stays 0, state STOPPED, tick silent.
  - Send div_half=3, enable=1 -> the first edge occurs 3 cycles after apply.
- Zero clamp: cfg_div_half=0 -> div_half_active=1, clk_div toggles every cycle.
- Backpressure: hold cfg_valid in PENDING -> cfg_ready=0, no second accept until the boundary. The accept that coincides with a boundary applies at the next boundary.
- Reset mid-PENDING: assert reset_n=0 -> outputs return to reset values asynchronously and the pending configuration is discarded. With the optional feature, period_cnt counts 5 ticks and then clears on the next apply.
